// File: rtl/read_arbiter.sv
// Two-master AXI read arbiter: round-robin grant of one AR burst at a time, R channel routed back to the winner.
// AR reaches the slave one cycle after the master handshake; R is a zero-latency combinational pass-through.
module read_arbiter #(
  parameter int ID_BITS   = 4,
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int DATA_BITS = 32
) (
  input  logic                 AXI_CLK_i,
  input  logic                 AXI_RST_i,
  // master 0 AR
  input  logic [ID_BITS-1:0]   ARID_M0_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M0_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M0_i,
  input  logic [SIZE_BITS-1:0] ARSIZE_M0_i,
  input  logic [1:0]           ARBURST_M0_i,
  input  logic                 ARVALID_M0_i,
  output logic                 ARREADY_M0_o,
  // master 1 AR
  input  logic [ID_BITS-1:0]   ARID_M1_i,
  input  logic [ADDR_BITS-1:0] ARADDR_M1_i,
  input  logic [LEN_BITS-1:0]  ARLEN_M1_i,
  input  logic [SIZE_BITS-1:0] ARSIZE_M1_i,
  input  logic [1:0]           ARBURST_M1_i,
  input  logic                 ARVALID_M1_i,
  output logic                 ARREADY_M1_o,
  // master 0 R
  output logic [ID_BITS-1:0]   RID_M0_o,
  output logic [DATA_BITS-1:0] RDATA_M0_o,
  output logic [1:0]           RRESP_M0_o,
  output logic                 RLAST_M0_o,
  output logic                 RVALID_M0_o,
  input  logic                 RREADY_M0_i,
  // master 1 R
  output logic [ID_BITS-1:0]   RID_M1_o,
  output logic [DATA_BITS-1:0] RDATA_M1_o,
  output logic [1:0]           RRESP_M1_o,
  output logic                 RLAST_M1_o,
  output logic                 RVALID_M1_o,
  input  logic                 RREADY_M1_i,
  // slave AR
  output logic [IDS_BITS-1:0]  ARID_S_o,
  output logic [ADDR_BITS-1:0] ARADDR_S_o,
  output logic [LEN_BITS-1:0]  ARLEN_S_o,
  output logic [SIZE_BITS-1:0] ARSIZE_S_o,
  output logic [1:0]           ARBURST_S_o,
  output logic                 ARVALID_S_o,
  input  logic                 ARREADY_S_i,
  // slave R
  input  logic [IDS_BITS-1:0]  RID_S_i,
  input  logic [DATA_BITS-1:0] RDATA_S_i,
  input  logic [1:0]           RRESP_S_i,
  input  logic                 RLAST_S_i,
  input  logic                 RVALID_S_i,
  output logic                 RREADY_S_o
);

  localparam int TAG_BITS = IDS_BITS - ID_BITS;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 ptr;
  logic                 grant;
  logic                 sel;
  logic                 req_any;
  logic                 burst_done;
  logic [ID_BITS-1:0]   id_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [SIZE_BITS-1:0] size_q;
  logic [1:0]           burst_q;
  logic                 rid_tag_unused;

  // Slave-side tag bits are only used to route on the AR side; R follows the grant.
  assign rid_tag_unused = ^RID_S_i[IDS_BITS-1:ID_BITS];

  assign req_any = ARVALID_M0_i | ARVALID_M1_i;

  always_comb begin
    sel = 1'b0;
    if (ARVALID_M0_i && ARVALID_M1_i) begin
      sel = ptr;
    end else if (ARVALID_M1_i) begin
      sel = 1'b1;
    end
  end

  assign burst_done = (state == DATA) && RVALID_S_i && RREADY_S_o && RLAST_S_i;

  always_comb begin
    state_nxt    = state;
    ARREADY_M0_o = 1'b0;
    ARREADY_M1_o = 1'b0;
    ARVALID_S_o  = 1'b0;
    RREADY_S_o   = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          ARREADY_M0_o = ~sel;
          ARREADY_M1_o = sel;
          state_nxt    = ADDR;
        end
      end
      ADDR: begin
        ARVALID_S_o = 1'b1;
        if (ARREADY_S_i) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        RREADY_S_o = grant ? RREADY_M1_i : RREADY_M0_i;
        if (RVALID_S_i && RREADY_S_o && RLAST_S_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AR payload is only driven while presenting to the slave so idle outputs stay zero.
  always_comb begin
    ARID_S_o    = '0;
    ARADDR_S_o  = '0;
    ARLEN_S_o   = '0;
    ARSIZE_S_o  = '0;
    ARBURST_S_o = '0;
    if (state == ADDR) begin
      ARID_S_o    = {{(TAG_BITS-1){1'b0}}, grant, id_q};
      ARADDR_S_o  = addr_q;
      ARLEN_S_o   = len_q;
      ARSIZE_S_o  = size_q;
      ARBURST_S_o = burst_q;
    end
  end

  always_comb begin
    RID_M0_o    = '0;
    RDATA_M0_o  = '0;
    RRESP_M0_o  = '0;
    RLAST_M0_o  = 1'b0;
    RVALID_M0_o = 1'b0;
    RID_M1_o    = '0;
    RDATA_M1_o  = '0;
    RRESP_M1_o  = '0;
    RLAST_M1_o  = 1'b0;
    RVALID_M1_o = 1'b0;
    if (state == DATA) begin
      if (grant) begin
        RID_M1_o    = RID_S_i[ID_BITS-1:0];
        RDATA_M1_o  = RDATA_S_i;
        RRESP_M1_o  = RRESP_S_i;
        RLAST_M1_o  = RLAST_S_i;
        RVALID_M1_o = RVALID_S_i;
      end else begin
        RID_M0_o    = RID_S_i[ID_BITS-1:0];
        RDATA_M0_o  = RDATA_S_i;
        RRESP_M0_o  = RRESP_S_i;
        RLAST_M0_o  = RLAST_S_i;
        RVALID_M0_o = RVALID_S_i;
      end
    end
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (!AXI_RST_i) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      grant   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        grant   <= sel;
        id_q    <= sel ? ARID_M1_i    : ARID_M0_i;
        addr_q  <= sel ? ARADDR_M1_i  : ARADDR_M0_i;
        len_q   <= sel ? ARLEN_M1_i   : ARLEN_M0_i;
        size_q  <= sel ? ARSIZE_M1_i  : ARSIZE_M0_i;
        burst_q <= sel ? ARBURST_M1_i : ARBURST_M0_i;
      end
      // Fairness only advances once a burst has fully drained.
      if (burst_done) begin
        ptr <= ~grant;
      end
    end
  end

endmodule

// File: tb/tb_read_arbiter.sv
// Directed table-driven bench for read_arbiter: each row is one clock of stimulus plus the expected outputs in that cycle.
module tb_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic        av0, av1, ar0, ar1;
  logic [3:0]  rid0, rid1;
  logic [31:0] rd0, rd1;
  logic [1:0]  rr0_resp, rr1_resp;
  logic        rl0, rl1, rv0, rv1, rr0, rr1;
  logic [7:0]  arid_s;
  logic [31:0] araddr_s;
  logic [3:0]  arlen_s;
  logic [2:0]  arsize_s;
  logic [1:0]  arburst_s;
  logic        arvalid_s, arready_s;
  logic [7:0]  rid_s;
  logic [31:0] rdata_s;
  logic        rlast_s, rvalid_s, rready_s;

  int tests  = 0;
  int failed = 0;

  read_arbiter dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .ARID_M0_i(4'h3), .ARADDR_M0_i(32'h1000), .ARLEN_M0_i(4'd3), .ARSIZE_M0_i(3'd2),
    .ARBURST_M0_i(2'b01), .ARVALID_M0_i(av0), .ARREADY_M0_o(ar0),
    .ARID_M1_i(4'h5), .ARADDR_M1_i(32'h2000), .ARLEN_M1_i(4'd1), .ARSIZE_M1_i(3'd1),
    .ARBURST_M1_i(2'b10), .ARVALID_M1_i(av1), .ARREADY_M1_o(ar1),
    .RID_M0_o(rid0), .RDATA_M0_o(rd0), .RRESP_M0_o(rr0_resp), .RLAST_M0_o(rl0),
    .RVALID_M0_o(rv0), .RREADY_M0_i(rr0),
    .RID_M1_o(rid1), .RDATA_M1_o(rd1), .RRESP_M1_o(rr1_resp), .RLAST_M1_o(rl1),
    .RVALID_M1_o(rv1), .RREADY_M1_i(rr1),
    .ARID_S_o(arid_s), .ARADDR_S_o(araddr_s), .ARLEN_S_o(arlen_s), .ARSIZE_S_o(arsize_s),
    .ARBURST_S_o(arburst_s), .ARVALID_S_o(arvalid_s), .ARREADY_S_i(arready_s),
    .RID_S_i(rid_s), .RDATA_S_i(rdata_s), .RRESP_S_i(2'b10), .RLAST_S_i(rlast_s),
    .RVALID_S_i(rvalid_s), .RREADY_S_o(rready_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_f = {rst_n, av0, av1, arready_s, rvalid_s, rlast_s, rready0, rready1}
  // ex_f = {arready0, arready1, arvalid_s, rready_s, rvalid0, rvalid1, rlast0, rlast1}
  typedef struct {
    logic [7:0]  in_f;
    logic [7:0]  rid;
    logic [31:0] rdat;
    logic [7:0]  ex_f;
    logic [7:0]  ex_arid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [7:0] in_f, input logic [7:0] rid,
                              input logic [31:0] rdat, input logic [7:0] ex_f,
                              input logic [7:0] ex_arid);
    vec_t v;
    v.in_f = in_f; v.rid = rid; v.rdat = rdat; v.ex_f = ex_f; v.ex_arid = ex_arid;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  task automatic check_row(input int s, input vec_t v);
    logic avs, m1, e_rv0, e_rv1;
    avs   = v.ex_f[5];
    m1    = v.ex_arid[4];
    e_rv0 = v.ex_f[3];
    e_rv1 = v.ex_f[2];
    chk("arready_m0", s, {31'd0, ar0}, {31'd0, v.ex_f[7]});
    chk("arready_m1", s, {31'd0, ar1}, {31'd0, v.ex_f[6]});
    chk("arvalid_s",  s, {31'd0, arvalid_s}, {31'd0, avs});
    chk("rready_s",   s, {31'd0, rready_s}, {31'd0, v.ex_f[4]});
    chk("rvalid_m0",  s, {31'd0, rv0}, {31'd0, e_rv0});
    chk("rvalid_m1",  s, {31'd0, rv1}, {31'd0, e_rv1});
    chk("rlast_m0",   s, {31'd0, rl0}, {31'd0, v.ex_f[1]});
    chk("rlast_m1",   s, {31'd0, rl1}, {31'd0, v.ex_f[0]});
    chk("arid_s",     s, {24'd0, arid_s}, {24'd0, v.ex_arid});
    chk("araddr_s",   s, araddr_s, avs ? (m1 ? 32'h2000 : 32'h1000) : 32'h0);
    chk("arlen_s",    s, {28'd0, arlen_s}, avs ? (m1 ? 32'd1 : 32'd3) : 32'd0);
    chk("arsize_s",   s, {29'd0, arsize_s}, avs ? (m1 ? 32'd1 : 32'd2) : 32'd0);
    chk("arburst_s",  s, {30'd0, arburst_s}, avs ? (m1 ? 32'd2 : 32'd1) : 32'd0);
    chk("rid_m0",     s, {28'd0, rid0}, e_rv0 ? {28'd0, v.rid[3:0]} : 32'd0);
    chk("rid_m1",     s, {28'd0, rid1}, e_rv1 ? {28'd0, v.rid[3:0]} : 32'd0);
    chk("rdata_m0",   s, rd0, e_rv0 ? v.rdat : 32'd0);
    chk("rdata_m1",   s, rd1, e_rv1 ? v.rdat : 32'd0);
    chk("rresp_m0",   s, {30'd0, rr0_resp}, e_rv0 ? 32'd2 : 32'd0);
    chk("rresp_m1",   s, {30'd0, rr1_resp}, e_rv1 ? 32'd2 : 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; av0 = 1'b0; av1 = 1'b0; arready_s = 1'b0; rvalid_s = 1'b0;
    rlast_s = 1'b0; rr0 = 1'b0; rr1 = 1'b0; rid_s = 8'h00; rdata_s = 32'h0;

    // reset held
    vecs.push_back(mk(8'b0000_0000, 8'h00, 32'h0,        8'b0000_0000, 8'h00));
    // M0 LEN=3 burst: grant, AR, four beats
    vecs.push_back(mk(8'b1100_0000, 8'h00, 32'h0,        8'b1000_0000, 8'h00));
    vecs.push_back(mk(8'b1001_0000, 8'h00, 32'h0,        8'b0010_0000, 8'h03));
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hA000_0000, 8'b0001_1000, 8'h00));
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hA000_0001, 8'b0001_1000, 8'h00));
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hA000_0002, 8'b0001_1000, 8'h00));
    vecs.push_back(mk(8'b1000_1110, 8'h03, 32'hA000_0003, 8'b0001_1010, 8'h00));
    // stray slave RVALID in IDLE is not forwarded
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hDEAD_BEEF, 8'b0000_0000, 8'h00));
    // reset while pointer favours M1, then both request: M0 must win
    vecs.push_back(mk(8'b0000_0000, 8'h00, 32'h0,        8'b0000_0000, 8'h00));
    vecs.push_back(mk(8'b1110_0000, 8'h00, 32'h0,        8'b1000_0000, 8'h00));
    vecs.push_back(mk(8'b1111_0000, 8'h00, 32'h0,        8'b0010_0000, 8'h03));
    vecs.push_back(mk(8'b1110_1110, 8'h03, 32'hC000_0000, 8'b0001_1010, 8'h00));
    // both still requesting: M1's turn
    vecs.push_back(mk(8'b1110_0000, 8'h00, 32'h0,        8'b0100_0000, 8'h00));
    vecs.push_back(mk(8'b1101_0000, 8'h00, 32'h0,        8'b0010_0000, 8'h15));
    // M1 RREADY 1,0,1 over a two-beat burst
    vecs.push_back(mk(8'b1100_1001, 8'h15, 32'hB000_0000, 8'b0001_0100, 8'h00));
    vecs.push_back(mk(8'b1100_1100, 8'h15, 32'hB000_0001, 8'b0000_0101, 8'h00));
    vecs.push_back(mk(8'b1100_1101, 8'h15, 32'hB000_0001, 8'b0001_0101, 8'h00));
    // waiting M0 now served
    vecs.push_back(mk(8'b1100_0000, 8'h00, 32'h0,        8'b1000_0000, 8'h00));
    // slave AR stall for 5 cycles, handshake on the 6th
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(8'b1000_0000, 8'h00, 32'h0,      8'b0010_0000, 8'h03));
    vecs.push_back(mk(8'b1001_0000, 8'h00, 32'h0,        8'b0010_0000, 8'h03));
    // beat 1, then reset asserted: still in DATA this cycle, abandoned afterwards
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hD000_0000, 8'b0001_1000, 8'h00));
    vecs.push_back(mk(8'b0000_1010, 8'h03, 32'hD000_0001, 8'b0001_1000, 8'h00));
    vecs.push_back(mk(8'b1000_1010, 8'h03, 32'hD000_0002, 8'b0000_0000, 8'h00));
    // lone M1 request after reset, LEN=0 style single beat
    vecs.push_back(mk(8'b1010_0000, 8'h00, 32'h0,        8'b0100_0000, 8'h00));
    vecs.push_back(mk(8'b1001_0000, 8'h00, 32'h0,        8'b0010_0000, 8'h15));
    vecs.push_back(mk(8'b1000_1101, 8'h15, 32'hE000_0000, 8'b0001_0101, 8'h00));
    vecs.push_back(mk(8'b1000_0000, 8'h00, 32'h0,        8'b0000_0000, 8'h00));

    repeat (2) @(posedge clk);

    foreach (vecs[s]) begin
      @(posedge clk);
      #1;
      {rst_n, av0, av1, arready_s, rvalid_s, rlast_s, rr0, rr1} = vecs[s].in_f;
      rid_s   = vecs[s].rid;
      rdata_s = vecs[s].rdat;
      #3;
      check_row(s, vecs[s]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/read_arbiter.md
READ_ARBITER -- requirements
Module: read_arbiter

Interface
REQ-001 Parameters: ID_BITS, 4, master transaction ID width; IDS_BITS, 8, slave-side ID width (ID_BITS + 4-bit master tag); ADDR_BITS, 32, address width; LEN_BITS, 4, burst length width; SIZE_BITS, 3, burst size width; DATA_BITS, 32, read data width.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 AXI_CLK_i  in  1  clock; all state updates on its rising edge.
REQ-004 AXI_RST_i  in  1  synchronous active-low reset.
REQ-005 ARID_Mx_i (x=0,1)  in  ID_BITS  master AR ID.
REQ-006 ARADDR_Mx_i / ARLEN_Mx_i / ARSIZE_Mx_i / ARBURST_Mx_i  in  ADDR_BITS/LEN_BITS/SIZE_BITS/2  master AR payload.
REQ-007 ARVALID_Mx_i  in  1  master AR valid; ARREADY_Mx_o  out  1  master AR ready.
REQ-008 RID_Mx_o  out  ID_BITS; RDATA_Mx_o  out  DATA_BITS; RRESP_Mx_o  out  2; RLAST_Mx_o  out  1; RVALID_Mx_o  out  1: R channel to master x.
REQ-009 RREADY_Mx_i  in  1  master R ready.
REQ-010 ARID_S_o  out  IDS_BITS; ARADDR_S_o/ARLEN_S_o/ARSIZE_S_o/ARBURST_S_o  out  ADDR_BITS/LEN_BITS/SIZE_BITS/2; ARVALID_S_o  out  1: AR to slave.
REQ-011 ARREADY_S_i  in  1  slave AR ready.
REQ-012 RID_S_i  in  IDS_BITS; RDATA_S_i  in  DATA_BITS; RRESP_S_i  in  2; RLAST_S_i  in  1; RVALID_S_i  in  1: R from slave; RREADY_S_o  out  1.

Function
REQ-013 FSM states: IDLE, ADDR, DATA; one read burst in flight at a time.
REQ-014 IDLE: if any ARVALID_Mx_i, grant one master; ARREADY_Mx_o=1 combinationally for granted master only, same cycle; latch its AR payload and grant; next state ADDR.
REQ-015 Arbitration: round-robin; priority pointer selects preferred master; only one requester -> it wins regardless of pointer.
REQ-016 Pointer updates only on completion of a burst (REQ-020): set to the master not just served.
REQ-017 ADDR: ARVALID_S_o=1 with latched payload, stable until ARREADY_S_i=1; ARID_S_o = {tag, latched ARID}, tag = 4'd0 for M0, 4'd1 for M1; on ARVALID_S_o & ARREADY_S_i -> DATA.
REQ-018 AR latency: master handshake in cycle N -> ARVALID_S_o first high in cycle N+1.
REQ-019 DATA: granted master's R outputs = slave R inputs (RID_Mx_o = RID_S_i[ID_BITS-1:0]); RREADY_S_o = granted RREADY_Mx_i; non-granted master RVALID=0, R payload 0; combinational pass-through, zero latency.
REQ-020 DATA: on RVALID_S_i & RREADY_S_o & RLAST_S_i -> IDLE; RLAST handshake without RREADY holds DATA.
REQ-021 ARREADY_Mx_o=0 in ADDR and DATA; new requests wait; ARVALID_Mx_i dropped while waiting is ignored.
REQ-022 RVALID_S_i in IDLE/ADDR: RREADY_S_o=0, data not forwarded.
REQ-023 Both ARVALID in IDLE same cycle: pointer master granted, other ARREADY=0.
REQ-024 LEN=0 burst: single beat with RLAST=1 completes burst, normal path.

Reset
REQ-025 AXI_RST_i=0 at rising edge: state IDLE, pointer M0, latched payload and grant cleared.
REQ-026 During and after reset until a request: all ARREADY_Mx_o, RVALID_Mx_o, ARVALID_S_o, RREADY_S_o = 0; all payload outputs 0.
REQ-027 Reset mid-ADDR or mid-DATA: burst abandoned, ARVALID_S_o=0 next cycle, no R forwarded.

Verification
REQ-028 M0 ARVALID, ARID=4'h3, ARADDR=32'h1000, LEN=3 cycle N -> ARREADY_M0 cycle N, ARVALID_S cycle N+1 with ARID_S=8'h03; 4 beats forwarded to M0, RID_M0=4'h3, IDLE after RLAST.
REQ-029 M0 and M1 both valid after reset -> M0 granted (ARID_S[7:4]=0); after its RLAST, M1 granted (ARID_S[7:4]=1); M0 re-requesting keeps waiting one turn.
REQ-030 ARREADY_S_i held 0 for 5 cycles -> ARVALID_S_o and payload stable all 5 cycles; handshake cycle 6 -> DATA.
REQ-031 M1 RREADY toggles 1,0,1 during 2-beat burst -> RREADY_S_o mirrors it, beat not lost, IDLE only after RLAST accepted.
REQ-032 Reset asserted in DATA after beat 1 of 4 -> next cycle all outputs 0, IDLE, pointer M0; new M1 request then granted normally.
